// File: rtl/package_bus.sv
// Shared bus types: t_bus request, t_rsp response payload and the target FSM state.
package package_bus;

    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] dat;
    } t_bus;

    typedef struct packed {
        logic        err;
        logic [31:0] dat;
    } t_rsp;

    typedef enum logic {IDLE, RESP} t_target_state;

endpackage

// File: rtl/bus_target.sv
// Memory-mapped responder: valid/ready request in, one response out per request, flop register file.
// Optional macro BUS_TARGET_ERR_EN enables the upper-address range check and rsp_err.
module bus_target
    import package_bus::*;
#(
    parameter int DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_vld,
    output logic        req_rdy,
    input  logic        req_we,
    input  t_bus        req_bus,
    output logic        rsp_vld,
    input  logic        rsp_rdy,
    output logic [31:0] rsp_dat,
    output logic        rsp_err
);

    localparam int AW = $clog2(DEPTH);

    t_target_state state_q, state_d;
    t_rsp          rsp_q, rsp_d;
    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] idx;
    logic          accept;
    logic          addr_err;

    assign idx    = req_bus.adr[AW+1:2];
    assign accept = req_vld && req_rdy;

`ifdef BUS_TARGET_ERR_EN
    assign addr_err = |req_bus.adr[31:AW+2];
`else
    assign addr_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // In RESP an accept implies rsp_rdy, so the old response leaves as the new one arrives.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = RESP;
            RESP:    if (!accept && rsp_rdy) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rsp_vld = (state_q == RESP);
        req_rdy = (state_q != RESP) || rsp_rdy;
    end

    always_comb begin
        rsp_d.err = addr_err;
        rsp_d.dat = (req_we || addr_err) ? '0 : mem[idx];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      rsp_q <= '0;
        else if (accept) rsp_q <= rsp_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (accept && req_we && !addr_err) begin
            mem[idx] <= req_bus.dat;
        end
    end

    assign rsp_dat = rsp_q.dat;
    assign rsp_err = rsp_q.err;

endmodule

// File: tb/tb_bus_target.sv
// Directed and scoreboarded random checks for bus_target (DEPTH=16); follows BUS_TARGET_ERR_EN.
module tb_bus_target;
    import package_bus::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_vld;
    logic        req_rdy;
    logic        req_we;
    t_bus        req_bus;
    logic        rsp_vld;
    logic        rsp_rdy;
    logic [31:0] rsp_dat;
    logic        rsp_err;

    int total = 0;
    int bad   = 0;

    bus_target #(.DEPTH(16)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_vld (req_vld),
        .req_rdy (req_rdy),
        .req_we  (req_we),
        .req_bus (req_bus),
        .rsp_vld (rsp_vld),
        .rsp_rdy (rsp_rdy),
        .rsp_dat (rsp_dat),
        .rsp_err (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic vld, input logic we, input logic [31:0] adr, input logic [31:0] dat);
        req_vld     = vld;
        req_we      = we;
        req_bus.adr = adr;
        req_bus.dat = dat;
    endtask

    // Single transaction with rsp_rdy held high; checks the response one cycle after accept.
    task automatic xact(input string tag, input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [31:0] exp_dat, input logic exp_err);
        rsp_rdy = 1'b1;
        set_req(1'b1, we, adr, dat);
        @(negedge clk);
        check({tag, "_rdy"}, 32'(req_rdy), 32'd1);
        step();
        set_req(1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        check({tag, "_vld"}, 32'(rsp_vld), 32'd1);
        check({tag, "_dat"}, rsp_dat, exp_dat);
        check({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
        step();
    endtask

    logic [31:0] mdl [16];
    t_rsp        exp_q [$];
    t_rsp        e;
    t_rsp        prev;
    logic        prev_stall;
    logic        acc;
    int          sent;
    int          done;

    initial begin
        rst_n   = 1'b0;
        rsp_rdy = 1'b0;
        set_req(1'b0, 1'b0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_vld", 32'(rsp_vld), 32'd0);
        check("rst_rdy", 32'(req_rdy), 32'd1);
        check("rst_dat", rsp_dat, 32'd0);
        check("rst_err", 32'(rsp_err), 32'd0);
        step();
        rst_n = 1'b1;
        step();

        xact("rd0", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);

        // Back-to-back write then read of the same word.
        rsp_rdy = 1'b1;
        set_req(1'b1, 1'b1, 32'h8, 32'hDEAD_BEEF);
        @(negedge clk);
        check("b2b_rdy0", 32'(req_rdy), 32'd1);
        step();
        set_req(1'b1, 1'b0, 32'h8, 32'h0);
        @(negedge clk);
        check("b2b_wvld", 32'(rsp_vld), 32'd1);
        check("b2b_wdat", rsp_dat, 32'h0);
        check("b2b_rdy1", 32'(req_rdy), 32'd1);
        step();
        set_req(1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        check("b2b_rvld", 32'(rsp_vld), 32'd1);
        check("b2b_rdat", rsp_dat, 32'hDEAD_BEEF);
        step();
        @(negedge clk);
        check("b2b_idle", 32'(rsp_vld), 32'd0);

        // Stall: a pending read of 0x4 must wait until the write response leaves.
        step();
        rsp_rdy = 1'b0;
        set_req(1'b1, 1'b1, 32'h4, 32'h1234_5678);
        step();
        set_req(1'b1, 1'b0, 32'h4, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stl_rdy", 32'(req_rdy), 32'd0);
            check("stl_vld", 32'(rsp_vld), 32'd1);
            check("stl_dat", rsp_dat, 32'h0);
            step();
        end
        rsp_rdy = 1'b1;
        @(negedge clk);
        check("stl_go_rdy", 32'(req_rdy), 32'd1);
        check("stl_go_vld", 32'(rsp_vld), 32'd1);
        step();
        set_req(1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        check("stl_rd_vld", 32'(rsp_vld), 32'd1);
        check("stl_rd_dat", rsp_dat, 32'h1234_5678);
        step();

`ifdef BUS_TARGET_ERR_EN
        xact("oor_wr", 1'b1, 32'h40, 32'hAAAA_AAAA, 32'h0, 1'b1);
        xact("oor_rd0", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        xact("oor_rd", 1'b0, 32'h40, 32'h0, 32'h0, 1'b1);
`else
        xact("alias_wr", 1'b1, 32'h40, 32'hAAAA_AAAA, 32'h0, 1'b0);
        xact("alias_rd0", 1'b0, 32'h0, 32'h0, 32'hAAAA_AAAA, 1'b0);
        xact("alias_rd", 1'b0, 32'h40, 32'h0, 32'hAAAA_AAAA, 1'b0);
`endif

        // Reset while a response is stalled.
        rsp_rdy = 1'b0;
        set_req(1'b1, 1'b1, 32'h10, 32'h0000_0055);
        step();
        set_req(1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        check("mrst_pre", 32'(rsp_vld), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mrst_vld", 32'(rsp_vld), 32'd0);
        check("mrst_dat", rsp_dat, 32'h0);
        step();
        rst_n = 1'b1;
        step();
        xact("mrst_rd8", 1'b0, 32'h8, 32'h0, 32'h0, 1'b0);
        xact("mrst_rd4", 1'b0, 32'h4, 32'h0, 32'h0, 1'b0);
        xact("mrst_rd10", 1'b0, 32'h10, 32'h0, 32'h0, 1'b0);

        // Random traffic against an in-order scoreboard; addresses stay in range.
        for (int i = 0; i < 16; i++) mdl[i] = 32'h0;
        sent = 0;
        done = 0;
        prev_stall = 1'b0;
        prev = '0;
        rsp_rdy = 1'b0;
        for (int cyc = 0; cyc < 20000 && done < 1000; cyc++) begin
            @(negedge clk);
            if (prev_stall) begin
                check("rnd_hold_vld", 32'(rsp_vld), 32'd1);
                check("rnd_hold_dat", rsp_dat, prev.dat);
            end
            prev_stall = rsp_vld && !rsp_rdy;
            prev.err   = rsp_err;
            prev.dat   = rsp_dat;
            if (rsp_vld && rsp_rdy) begin
                if (exp_q.size() == 0) begin
                    check("rnd_extra", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("rnd_dat", rsp_dat, e.dat);
                    check("rnd_err", 32'(rsp_err), 32'(e.err));
                    done++;
                end
            end
            acc = req_vld && req_rdy;
            if (acc) begin
                e.err = 1'b0;
                e.dat = req_we ? 32'h0 : mdl[req_bus.adr[5:2]];
                exp_q.push_back(e);
                if (req_we) mdl[req_bus.adr[5:2]] = req_bus.dat;
            end
            step();
            if (!req_vld || acc) begin
                if (sent < 1000 && $urandom_range(0, 3) != 0) begin
                    set_req(1'b1, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)), $urandom);
                    sent++;
                end else begin
                    req_vld = 1'b0;
                end
            end
            rsp_rdy = ($urandom_range(0, 9) < 7);
        end
        check("rnd_done", 32'(done), 32'd1000);
        check("rnd_left", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
